// File: rtl/sparse_sched_pkg.sv
// sparse_pkg: shared constants, state encoding and sizing helper for the
// sparse vector-product job controller (sparse_sched).
package sparse_pkg;

    localparam int DATA_W    = 8;
    localparam int N         = 16;
    localparam int VEC_W     = DATA_W * N;
    localparam int OUT_W     = 20;
    localparam int JOB_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        CALC  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of a down-counter that must hold values up to max(a,b)-1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sparse_sched_lat_cnt.sv
// sparse_lat_cnt: loadable down-counter with a zero flag. Used by the job
// controller to time the datapath clear and calculation phases.
module sparse_lat_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    // Load takes priority over decrement; the count saturates at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sparse_sched.sv
// sparse_sched: job controller for the sparse vector-product datapath.
// Accepts one operand pair, holds it on dp_a/dp_b, sequences datapath
// clear and calculation phases, then buffers the result in a one-entry
// output register with its own valid/ready handshake.
// Optional feature macro: SPARSE_SCHED_ZERO_SKIP_EN (a job with an all-zero
// operand bypasses CLEAR/CALC and completes with a zero result).
module sparse_sched #(
    parameter int DATA_W   = 8,
    parameter int N        = 16,
    parameter int OUT_W    = 20,
    parameter int CLR_CYC  = 1,
    parameter int CALC_LAT = 20
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_W*N-1:0]             vec_a,
    input  logic [DATA_W*N-1:0]             vec_b,
    output logic                            dp_rst,
    output logic [DATA_W*N-1:0]             dp_a,
    output logic [DATA_W*N-1:0]             dp_b,
    input  logic [OUT_W-1:0]                dp_result,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUT_W-1:0]                out_data,
    output logic                            busy,
    output logic [sparse_pkg::JOB_CNT_W-1:0] job_cnt
);

    import sparse_pkg::*;

    localparam int CNT_W = cnt_width(CLR_CYC, CALC_LAT);

    state_t           state;
    logic             accept;
    logic             skip;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    // Datapath held in reset while idle and during the clear phase; released
    // in CALC and kept released in DONE so its result stays put.
    assign dp_rst   = (state == IDLE) || (state == CLEAR);
    assign accept   = in_valid && in_ready;

`ifdef SPARSE_SCHED_ZERO_SKIP_EN
    assign skip = (vec_a == '0) || (vec_b == '0);
`else
    assign skip = 1'b0;
`endif

    // Phase timer control: load on phase entry, count down inside a phase.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(CLR_CYC - 1);
                end
            end
            CLEAR: begin
                if (cnt_zero) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(CALC_LAT - 1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            CALC: begin
                cnt_dec = !cnt_zero;
            end
            default: begin
                cnt_dec = 1'b0;
            end
        endcase
    end

    sparse_lat_cnt #(
        .W(CNT_W)
    ) u_lat_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .dec     (cnt_dec),
        .load_val(cnt_load_val),
        .cnt     (cnt),
        .zero    (cnt_zero)
    );

    // Job FSM with registered operand, result and completion-count outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            dp_a      <= '0;
            dp_b      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            job_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dp_a <= vec_a;
                        dp_b <= vec_b;
                        if (skip) begin
                            out_data  <= '0;
                            out_valid <= 1'b1;
                            job_cnt   <= job_cnt + JOB_CNT_W'(1);
                            state     <= DONE;
                        end else begin
                            state <= CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    if (cnt_zero) begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (cnt_zero) begin
                        out_data  <= dp_result;
                        out_valid <= 1'b1;
                        job_cnt   <= job_cnt + JOB_CNT_W'(1);
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_sched.sv
// tb_sparse_sched: scoreboard bench for sparse_sched with a behavioural
// datapath whose result only becomes valid CALC_LAT cycles after dp_rst falls.
module tb_sparse_sched;

    localparam int DW   = 8;
    localparam int NN   = 16;
    localparam int VW   = DW * NN;
    localparam int OW   = 20;
    localparam int CLR  = 1;
    localparam int LAT  = 20;
    localparam int FULL = CLR + LAT;
`ifdef SPARSE_SCHED_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = FULL;
`endif

    typedef struct {
        logic [OW-1:0] data;
        logic [15:0]   cnt;
        int            lat;
        int            acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] vec_a = '0;
    logic [VW-1:0] vec_b = '0;
    logic          dp_rst;
    logic [VW-1:0] dp_a;
    logic [VW-1:0] dp_b;
    logic [OW-1:0] dp_result;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] out_data;
    logic          busy;
    logic [15:0]   job_cnt;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   dp_cyc;
    exp_t sb[$];
    exp_t cur;
    logic prev_ov = 1'b0;
    logic [15:0] e_cnt = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sparse_sched #(
        .DATA_W  (DW),
        .N       (NN),
        .OUT_W   (OW),
        .CLR_CYC (CLR),
        .CALC_LAT(LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .vec_a    (vec_a),
        .vec_b    (vec_b),
        .dp_rst   (dp_rst),
        .dp_a     (dp_a),
        .dp_b     (dp_b),
        .dp_result(dp_result),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy),
        .job_cnt  (job_cnt)
    );

    function automatic logic [OW-1:0] dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [OW-1:0] s;
        s = '0;
        for (int i = 0; i < NN; i++) s += OW'(a[i*DW +: DW]) * OW'(b[i*DW +: DW]);
        return s;
    endfunction

    // Behavioural datapath: garbage until LAT cycles after reset release.
    always @(posedge clk or negedge rst) begin
        if (!rst)            dp_cyc <= 0;
        else if (dp_rst)     dp_cyc <= 0;
        else if (dp_cyc < 1000) dp_cyc <= dp_cyc + 1;
    end
    assign dp_result = (!dp_rst && dp_cyc >= LAT - 1) ? dot(dp_a, dp_b) : 20'hABCDE;

    function automatic logic [VW-1:0] fill(input logic [7:0] v);
        return {NN{v}};
    endfunction

    function automatic logic [VW-1:0] ramp(input int start);
        logic [VW-1:0] r;
        for (int i = 0; i < NN; i++) r[i*DW +: DW] = 8'(start + i);
        return r;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pop one expectation per new out_valid, verify hold while stalled.
    always @(negedge clk) begin
        if (!rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: out_valid=1 with no job pending, out_data=%0d", out_data);
                end else begin
                    cur = sb.pop_front();
                    check("out_data", out_data, cur.data);
                    check("job_cnt", job_cnt, cur.cnt);
                    check("latency", cyc - cur.acc, cur.lat);
                end
            end else if (out_valid && prev_ov) begin
                check("out_hold", out_data, cur.data);
            end
            prev_ov = out_valid;
        end
    end

    // Present a pair, wait for acceptance, push the expected response.
    task automatic send(input logic [VW-1:0] a, input logic [VW-1:0] b,
                        input logic [OW-1:0] d, input int lat, output int acc);
        exp_t e;
        int   n;
        n        = 0;
        vec_a    = a;
        vec_b    = b;
        in_valid = 1'b1;
        acc      = -1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            return;
        end
        e_cnt  = e_cnt + 16'd1;
        e.data = d;
        e.cnt  = e_cnt;
        e.lat  = lat;
        e.acc  = cyc + 1;
        acc    = e.acc;
        sb.push_back(e);
        @(negedge clk);
        check("dp_a_latch", (dp_a == a), 1);
        check("dp_b_latch", (dp_b == b), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy || out_valid) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("valid_timeout", 0, 1);
    endtask

    initial begin
        int  a0, a1, a2;
        bit  bad_rdy, bad_ov;

        // Reset then idle
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_dp_rst", dp_rst, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_job_cnt", job_cnt, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single job: 16 x (1*1)
        out_ready = 1'b1;
        send(fill(8'h01), fill(8'h01), 20'd16, FULL, a0);
        in_valid = 1'b0;
        wait_idle();

        // Backpressure: 16 x (2*3) held while a second pair waits
        out_ready = 1'b0;
        send(fill(8'h02), fill(8'h03), 20'd96, FULL, a0);
        in_valid = 1'b0;
        wait_valid();
        vec_a    = ramp(0);
        vec_b    = fill(8'h01);
        in_valid = 1'b1;
        bad_rdy  = 1'b0;
        bad_ov   = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (in_ready)   bad_rdy = 1'b1;
            if (!out_valid) bad_ov  = 1'b1;
        end
        check("bp_in_ready_low", bad_rdy, 0);
        check("bp_valid_held", bad_ov, 0);
        check("bp_dp_a_stable", (dp_a == fill(8'h02)), 1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", in_ready, 1);
        check("bp_release_valid", out_valid, 0);
        // 0+1+...+15
        send(ramp(0), fill(8'h01), 20'd120, FULL, a0);
        in_valid = 1'b0;
        wait_idle();

        // Back-to-back with in_valid held high
        send(fill(8'hFF), fill(8'hFF), 20'd1040400, FULL, a0);
        send(fill(8'h10), fill(8'h01), 20'd256, FULL, a1);
        check("b2b_dp_a_hold", (dp_a == fill(8'h10)), 1);
        // 1^2+...+16^2
        send(ramp(1), ramp(1), 20'd1496, FULL, a2);
        in_valid = 1'b0;
        check("b2b_spacing1", a1 - a0, FULL + 2);
        check("b2b_spacing2", a2 - a1, FULL + 2);
        wait_idle();
        check("b2b_job_cnt", job_cnt, 6);

        // Reset 10 cycles into CALC aborts the job
        send(fill(8'h04), fill(8'h04), 20'd256, FULL, a0);
        in_valid = 1'b0;
        while (cyc < a0 + CLR + 10) @(negedge clk);
        check("pre_abort_busy", busy, 1);
        rst = 1'b0;
        void'(sb.pop_back());
        e_cnt = '0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_job_cnt", job_cnt, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_no_result", out_valid, 0);
        check("abort_cnt_after", job_cnt, 0);

        // Zero operands: skipped or full-latency depending on build
        send('0, fill(8'h05), 20'd0, ZLAT, a0);
        in_valid = 1'b0;
        wait_idle();
        send(fill(8'h07), '0, 20'd0, ZLAT, a0);
        in_valid = 1'b0;
        wait_idle();
        check("final_job_cnt", job_cnt, 2);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
